// File: rtl/spi_master.sv
// spi_master: byte-wide SPI mode-0 (CPOL=0, CPHA=0) master engine.
// One byte per txn_start/txn_done handshake, MSB first, plus free-running
// "force clock" cycles for dummy clocking while idle.
// Optional build macro SPI_MISO_SYNC_EN: routes spi_miso through a 2-flop
// synchronizer and samples late in the SCLK high phase (effective clk_div >= 2).
module spi_master #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [7:0]           data_tx,
    output logic [7:0]           data_rx,
    input  logic                 txn_start,
    output logic                 txn_done,
    input  logic                 force_clock,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FORCE
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [7:0]           shift_q;
    logic [7:0]           rx_q;
    logic [2:0]           bit_cnt_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 done_q;
    logic                 pend_q;

    logic                 half_end;
    logic                 sample_en;
    logic                 miso_bit;
    logic                 force_exit;
    logic [DIV_WIDTH-1:0] start_div;

    // An SCLK edge happens on the cycle the half-period counter sits at zero.
    assign half_end   = (cnt_q == '0);
    // Leave FORCE at the next low-side boundary when clocking is no longer
    // wanted or a transaction is waiting.
    assign force_exit = !force_clock || pend_q || txn_start;

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso_sync_q <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], spi_miso};
        end
    end

    // Sample on the last clk of the high phase so the synchronizer has settled.
    assign miso_bit  = miso_sync_q[1];
    assign sample_en = sclk_q && (cnt_q == DIV_WIDTH'(1));
    assign start_div = (clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clk_div;
`else
    // Sample directly on the cycle SCLK rises.
    assign miso_bit  = spi_miso;
    assign sample_en = !sclk_q && half_end;
    assign start_div = clk_div;
`endif

    // Control FSM with all SPI outputs and the handshake registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b1;
            pend_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A start (fresh or left pending by FORCE) beats force_clock.
                    if (txn_start || pend_q) begin
                        shift_q <= data_tx;
                        div_q   <= start_div;
                        pend_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end else if (force_clock) begin
                        div_q   <= clk_div;
                        cnt_q   <= clk_div;
                        mosi_q  <= 1'b1;
                        state_q <= ST_FORCE;
                    end
                end
                ST_LOAD: begin
                    done_q    <= 1'b0;
                    mosi_q    <= shift_q[7];
                    sclk_q    <= 1'b0;
                    cnt_q     <= div_q;
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Received bits enter at the LSB; bit 7 is always the next
                    // bit to drive, so the transmit byte drains as MISO fills in.
                    if (sample_en) begin
                        shift_q <= {shift_q[6:0], miso_bit};
                    end
                    if (half_end) begin
                        cnt_q  <= div_q;
                        sclk_q <= !sclk_q;
                        if (sclk_q) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // MOSI keeps the last bit; byte is complete.
                                rx_q    <= shift_q;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                mosi_q <= shift_q[7];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                ST_FORCE: begin
                    mosi_q <= 1'b1;
                    if (txn_start) begin
                        pend_q <= 1'b1;
                    end
                    if (half_end) begin
                        cnt_q <= div_q;
                        if (sclk_q) begin
                            // Always finish a high phase with a full-length fall.
                            sclk_q <= 1'b0;
                            if (force_exit) begin
                                state_q <= ST_IDLE;
                            end
                        end else if (force_exit) begin
                            state_q <= ST_IDLE;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign txn_done = done_q;
    assign data_rx  = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master. Stimulus pushes
// the expected transaction into a queue; a negedge monitor plays the SPI slave,
// measures SCLK phases and txn_done timing, and checks each finished byte.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic [7:0] data_tx = 8'd0;
    logic [7:0] data_rx;
    logic       txn_start = 1'b0;
    logic       txn_done;
    logic       force_clock = 1'b0;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso = 1'b0;

    spi_master #(.DIV_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div    (clk_div),
        .data_tx    (data_tx),
        .data_rx    (data_rx),
        .txn_start  (txn_start),
        .txn_done   (txn_done),
        .force_clock(force_clock),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         half;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor / slave-model state
    txn_t       cur;
    bit         busy = 1'b0;
    int         rise_idx = 0;
    logic [7:0] mosi_bits = 8'd0;
    logic [7:0] slave_sr = 8'd0;
    int         low_cnt = 0;
    int         hi_len = 0;
    int         last_gap = 0;
    int         ph_len = 0;
    bit         low_exact = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_done = 1'b1;
    int         n_started = 0;
    int         force_half = 1;

    function automatic int eff_half(input int d);
`ifdef SPI_MISO_SYNC_EN
        return ((d < 2) ? 2 : d) + 1;
`else
        return d + 1;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        n_cmp++;
        if (act < min) begin
            n_err++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] tx, input logic [7:0] rx, input int d);
        txn_t t;
        t.tx = tx;
        t.rx = rx;
        t.half = eff_half(d);
        clk_div = d[7:0];
        data_tx = tx;
        exp_q.push_back(t);
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
    endtask

    task automatic wait_all(input string name, input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || txn_done !== 1'b1) && k < bound) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0 || txn_done !== 1'b1) begin
            timeout(name);
            exp_q.delete();
        end
    endtask

    task automatic wait_started(input string name, input int target, input int bound);
        int k = 0;
        while (n_started < target && k < bound) begin
            tick();
            k++;
        end
        if (n_started < target) timeout(name);
    endtask

    // Monitor and SPI slave: sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy      = 1'b0;
            prev_sclk = 1'b0;
            prev_done = 1'b1;
            ph_len    = 0;
            low_exact = 1'b0;
            hi_len    = 0;
        end else begin
            if (spi_sclk == prev_sclk) begin
                ph_len++;
            end else begin
                if (prev_sclk) begin
                    chk("sclk_high_len", ph_len, busy ? cur.half : force_half);
                end else if (busy ? (rise_idx > 0) : low_exact) begin
                    chk("sclk_low_len", ph_len, busy ? cur.half : force_half);
                end else begin
                    chk_ge("sclk_low_min", ph_len, busy ? cur.half : force_half);
                end
                ph_len = 1;
                if (spi_sclk) begin
                    if (busy) begin
                        rise_idx++;
                        mosi_bits = {mosi_bits[6:0], spi_mosi};
                    end
                end else begin
                    low_exact = 1'b1;
                    if (busy) begin
                        slave_sr = {slave_sr[6:0], 1'b0};
                        spi_miso = slave_sr[7];
                    end
                end
            end
            if (!force_clock && !busy) low_exact = 1'b0;

            if (prev_done && !txn_done) begin
                last_gap = hi_len;
                n_started++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    cur       = exp_q[0];
                    busy      = 1'b1;
                    rise_idx  = 0;
                    mosi_bits = 8'd0;
                    low_cnt   = 0;
                    slave_sr  = cur.rx;
                    spi_miso  = slave_sr[7];
                    chk("start_sclk_low", int'(spi_sclk), 0);
                    chk("start_mosi_msb", int'(spi_mosi), int'(cur.tx[7]));
                end
            end
            if (!txn_done && busy) low_cnt++;

            if (!prev_done && txn_done) begin
                hi_len = 0;
                if (busy) begin
                    chk("busy_cycles", low_cnt, 16 * cur.half);
                    chk("rising_edges", rise_idx, 8);
                    chk("mosi_byte", int'(mosi_bits), int'(cur.tx));
                    chk("data_rx", int'(data_rx), int'(cur.rx));
                    $display("txn tx=%02h rx=%02h half=%0d busy=%0d", cur.tx, data_rx, cur.half, low_cnt);
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                    low_exact = 1'b0;
                end
            end
            if (txn_done) hi_len++;

            prev_sclk = spi_sclk;
            prev_done = txn_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int s0;
        int d;
        logic [7:0] rx_before;

        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_sclk", int'(spi_sclk), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_done", int'(txn_done), 1);
        chk("rst_rx", int'(data_rx), 0);
        cnt = 0;
        repeat (20) begin
            tick();
            if (spi_sclk !== 1'b0 || txn_done !== 1'b1 || spi_mosi !== 1'b0) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        // Fastest divider, directed byte
        issue(8'hA5, 8'h3C, 0);
        wait_all("t_a5", 1000);
        chk("rx_a5_held", int'(data_rx), 8'h3C);

        // Level-held start: two back-to-back bytes
        s0 = n_started;
        begin
            txn_t t;
            t.half = eff_half(3);
            t.tx = 8'h01; t.rx = 8'($urandom); exp_q.push_back(t);
            t.tx = 8'hFF; t.rx = 8'($urandom); exp_q.push_back(t);
        end
        clk_div = 8'd3;
        data_tx = 8'h01;
        txn_start = 1'b1;
        wait_started("b2b_first", s0 + 1, 100);
        data_tx = 8'hFF;
        wait_started("b2b_second", s0 + 2, 1000);
        txn_start = 1'b0;
        chk("b2b_gap", last_gap, 2);
        wait_all("t_b2b", 1000);

        // Random bytes, with inputs disturbed mid-transaction
        repeat (6) begin
            d = int'($urandom_range(0, 3));
            issue(8'($urandom), 8'($urandom), d);
            repeat (int'($urandom_range(2, 10))) tick();
            clk_div = 8'($urandom);
            data_tx = 8'($urandom);
            wait_all("t_rand", 1000);
        end

        // Free-running force clock
        clk_div = 8'd1;
        force_half = 2;
        rx_before = data_rx;
        force_clock = 1'b1;
        repeat (2) tick();
        cnt = 0;
        s0 = 0;
        repeat (48) begin
            tick();
            if (spi_mosi !== 1'b1 || txn_done !== 1'b1 || data_rx !== rx_before) cnt++;
            if (spi_sclk === 1'b1) s0++;
        end
        chk("force_outputs", cnt, 0);
        chk("force_high_cycles", s0, 24);
        cnt = 0;
        while (spi_sclk !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        force_clock = 1'b0;
        repeat (4) tick();
        chk("force_stop_low", int'(spi_sclk), 0);
        cnt = 0;
        repeat (10) begin
            tick();
            if (spi_sclk !== 1'b0) cnt++;
        end
        chk("force_stays_low", cnt, 0);

        // Start request arriving during FORCE
        force_clock = 1'b1;
        repeat (7) tick();
        s0 = n_started;
        issue(8'h9F, 8'($urandom), 1);
        wait_started("force_start", s0 + 1, 100);
        force_clock = 1'b0;
        wait_all("t_9f", 1000);

        // Reset in the middle of a byte
        issue(8'($urandom), 8'($urandom), 1);
        cnt = 0;
        while (!(busy && rise_idx >= 3) && cnt < 200) begin
            tick();
            cnt++;
        end
        if (!(busy && rise_idx >= 3)) timeout("mid_reset_wait");
        rst_n = 1'b0;
        tick();
        chk("midrst_sclk", int'(spi_sclk), 0);
        chk("midrst_done", int'(txn_done), 1);
        chk("midrst_rx", int'(data_rx), 0);
        chk("midrst_mosi", int'(spi_mosi), 0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) tick();

        issue(8'h55, 8'($urandom), 0);
        wait_all("t_55", 1000);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
